// File: rtl/ddp_token_rx_fifo.sv
// Clocked receive stage for the self-timed C pipeline: synchronises the
// active-low Send/Ack handshake and buffers tokens in a FWFT FIFO.
module ddp_token_rx_fifo #(
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                     CLK,
   input  logic                     MR,
   input  logic                     Send_in,
   input  logic [DATA_W-1:0]        Data_in,
   output logic                     Ack_out,
   output logic                     Out_valid,
   input  logic                     Out_ready,
   output logic [DATA_W-1:0]        Out_data,
   output logic [$clog2(DEPTH):0]   Count,
   output logic                     Full,
   output logic                     Empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef enum logic {
      IDLE  = 1'b0,
      ACKED = 1'b1
   } state_t;

   state_t              state;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                req_s;
   logic                ack_q;
   logic [DATA_W-1:0]   mem [DEPTH];
   logic [PW-1:0]       wr_ptr;
   logic [PW-1:0]       rd_ptr;
   logic [CW-1:0]       count_r;
   logic [CW-1:0]       count_nxt;
   logic                full_r;
   logic                empty_r;
   logic                valid_r;
   logic                wr_en;
   logic                pop;

   assign req_s = sync_q[SYNC_STAGES-1];

   // Gate on registered Full: a same-cycle pop never frees a slot early.
   assign wr_en = (state == IDLE) && !req_s && !full_r;
   assign pop   = valid_r && Out_ready;

   always_ff @(posedge CLK or posedge MR) begin
      if (MR) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], Send_in};
      end
   end

   always_ff @(posedge CLK or posedge MR) begin
      if (MR) begin
         state <= IDLE;
         ack_q <= 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               if (wr_en) begin
                  ack_q <= 1'b0;
                  state <= ACKED;
               end
            end
            ACKED: begin
               if (req_s) begin
                  ack_q <= 1'b1;
                  state <= IDLE;
               end
            end
            default: begin
               ack_q <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end

   always_comb begin
      count_nxt = count_r;
      unique case ({wr_en, pop})
         2'b10:   count_nxt = count_r + CW'(1);
         2'b01:   count_nxt = count_r - CW'(1);
         default: count_nxt = count_r;
      endcase
   end

   always_ff @(posedge CLK or posedge MR) begin
      if (MR) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_r <= '0;
         full_r  <= 1'b0;
         empty_r <= 1'b1;
         valid_r <= 1'b0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PW'(1);
         if (pop)   rd_ptr <= rd_ptr + PW'(1);
         count_r <= count_nxt;
         full_r  <= (count_nxt == CW'(DEPTH));
         empty_r <= (count_nxt == '0);
         valid_r <= (count_nxt != '0);
      end
   end

   // Storage needs no reset; occupancy alone decides what is visible.
   always_ff @(posedge CLK) begin
      if (wr_en) mem[wr_ptr] <= Data_in;
   end

   assign Ack_out   = ack_q;
   assign Out_valid = valid_r;
   assign Out_data  = mem[rd_ptr];
   assign Count     = count_r;
   assign Full      = full_r;
   assign Empty     = empty_r;

endmodule

// File: tb/tb_ddp_token_rx_fifo.sv
// Bench for ddp_token_rx_fifo: directed handshake scenarios followed by
// randomized traffic against a queue-based reference.
module tb_ddp_token_rx_fifo;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;
   localparam int SYNC   = 2;

   logic              CLK = 1'b0;
   logic              MR;
   logic              Send_in;
   logic [DATA_W-1:0] Data_in;
   logic              Ack_out;
   logic              Out_valid;
   logic              Out_ready;
   logic [DATA_W-1:0] Out_data;
   logic [2:0]        Count;
   logic              Full;
   logic              Empty;

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] q[$];

   ddp_token_rx_fifo #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .SYNC_STAGES(SYNC)
   ) dut (
      .CLK(CLK), .MR(MR), .Send_in(Send_in), .Data_in(Data_in),
      .Ack_out(Ack_out), .Out_valid(Out_valid), .Out_ready(Out_ready),
      .Out_data(Out_data), .Count(Count), .Full(Full), .Empty(Empty)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   // Full 4-phase handshake; returns edges from Send_in fall to Ack_out fall.
   task automatic send_token(input logic [31:0] d, output int lat);
      int n;
      Data_in = d;
      Send_in = 1'b0;
      lat = 0;
      do begin tick(); lat++; end while (Ack_out && lat < 50);
      Send_in = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!Ack_out && n < 50);
      check("ack_rise_lat", 32'(n), 32'(SYNC + 1));
   endtask

   task automatic wait_ack_rise;
      int n;
      Send_in = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!Ack_out && n < 50);
      check("ack_rise_lat", 32'(n), 32'(SYNC + 1));
   endtask

   task automatic pop_expect(input logic [31:0] exp);
      check("pop_valid", 32'(Out_valid), 32'd1);
      check("pop_data", Out_data, exp);
      Out_ready = 1'b1;
      tick();
      Out_ready = 1'b0;
   endtask

   initial begin
      int lat;
      int up_st, gap, wait_cnt;
      logic prev_ack, prev_valid, prev_ready;
      logic [31:0] prev_data;

      MR = 1'b1; Send_in = 1'b1; Data_in = '0; Out_ready = 1'b0;
      #100;
      MR = 1'b0;
      #1;
      check("rst_ack", 32'(Ack_out), 32'd1);
      check("rst_valid", 32'(Out_valid), 32'd0);
      check("rst_empty", 32'(Empty), 32'd1);
      check("rst_full", 32'(Full), 32'd0);
      check("rst_count", 32'(Count), 32'd0);

      // Single token latency and FWFT visibility
      tick();
      send_token(32'h0000_00A5, lat);
      check("single_lat", 32'(lat), 32'(SYNC + 1));
      check("single_count", 32'(Count), 32'd1);
      pop_expect(32'h0000_00A5);
      check("single_empty", 32'(Empty), 32'd1);

      // Fill to DEPTH, fifth token is held off until a pop frees a slot
      for (int i = 1; i <= 4; i++) begin
         send_token(32'(i), lat);
         check("fill_lat", 32'(lat), 32'(SYNC + 1));
      end
      check("fill_full", 32'(Full), 32'd1);
      check("fill_count", 32'(Count), 32'd4);
      Data_in = 32'd5;
      Send_in = 1'b0;
      repeat (10) tick();
      check("bp_ack", 32'(Ack_out), 32'd1);
      check("bp_count", 32'(Count), 32'd4);
      check("bp_head", Out_data, 32'd1);
      Out_ready = 1'b1;
      tick();
      Out_ready = 1'b0;
      check("gate_ack", 32'(Ack_out), 32'd1);
      check("gate_count", 32'(Count), 32'd3);
      tick();
      check("late_ack", 32'(Ack_out), 32'd0);
      check("late_count", 32'(Count), 32'd4);
      wait_ack_rise();
      for (int i = 2; i <= 5; i++) pop_expect(32'(i));
      check("drain_empty", 32'(Empty), 32'd1);

      // Simultaneous write and pop at Count=2 across pointer wrap
      q.delete();
      send_token(32'h100, lat); q.push_back(32'h100);
      send_token(32'h101, lat); q.push_back(32'h101);
      for (int i = 0; i < 10; i++) begin
         Data_in = 32'h200 + 32'(i);
         Send_in = 1'b0;
         tick(); tick();
         check("wp_head", Out_data, q[0]);
         Out_ready = 1'b1;
         tick();
         Out_ready = 1'b0;
         check("wp_ack", 32'(Ack_out), 32'd0);
         check("wp_count", 32'(Count), 32'd2);
         void'(q.pop_front());
         q.push_back(32'h200 + 32'(i));
         wait_ack_rise();
      end
      while (q.size() > 0) pop_expect(q.pop_front());

      // Reset in ACKED with tokens queued; held Send_in is a fresh token
      for (int i = 0; i < 3; i++) send_token(32'h300 + 32'(i), lat);
      Data_in = 32'h55;
      Send_in = 1'b0;
      repeat (SYNC + 1) tick();
      check("pre_mr_ack", 32'(Ack_out), 32'd0);
      #3 MR = 1'b1;
      #1;
      check("mr_ack", 32'(Ack_out), 32'd1);
      check("mr_count", 32'(Count), 32'd0);
      check("mr_valid", 32'(Out_valid), 32'd0);
      check("mr_empty", 32'(Empty), 32'd1);
      #10 MR = 1'b0;
      lat = 0;
      do begin tick(); lat++; end while (Ack_out && lat < 50);
      check("mr_relat", 32'(lat), 32'(SYNC + 1));
      check("mr_recount", 32'(Count), 32'd1);
      check("mr_redata", Out_data, 32'h55);
      wait_ack_rise();
      pop_expect(32'h55);

      // Consumer stall holds head
      send_token(32'h66, lat);
      send_token(32'h77, lat);
      repeat (20) begin
         tick();
         check("hold_data", Out_data, 32'h66);
         check("hold_valid", 32'(Out_valid), 32'd1);
      end
      pop_expect(32'h66);
      pop_expect(32'h77);

      // Randomized traffic: tokens enter the model when Ack_out falls,
      // leave it when a valid head is taken.
      q.delete();
      up_st = 0; gap = 0; wait_cnt = 0;
      prev_ack = Ack_out; prev_valid = Out_valid;
      prev_ready = 1'b0; prev_data = Out_data;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         tick();
         if (prev_valid && prev_ready) begin
            if (q.size() > 0) begin
               check("rnd_pop", prev_data, q[0]);
               void'(q.pop_front());
            end
         end
         if (prev_ack && !Ack_out) q.push_back(Data_in);
         check("rnd_count", 32'(Count), 32'(q.size()));
         check("rnd_valid", 32'(Out_valid), 32'(q.size() != 0));
         check("rnd_full", 32'(Full), 32'(q.size() == DEPTH));
         check("rnd_empty", 32'(Empty), 32'(q.size() == 0));
         if (q.size() > 0) check("rnd_head", Out_data, q[0]);
         unique case (up_st)
            0: begin
               if (gap == 0) begin
                  Data_in = $urandom;
                  Send_in = 1'b0;
                  up_st = 1;
                  wait_cnt = 0;
               end else gap--;
            end
            1: begin
               if (!Ack_out) begin
                  Send_in = 1'b1;
                  up_st = 2;
                  wait_cnt = 0;
               end else wait_cnt++;
            end
            default: begin
               if (Ack_out) begin
                  up_st = 0;
                  gap = $urandom_range(0, 3);
               end else wait_cnt++;
            end
         endcase
         if (wait_cnt > 300) begin
            check("up_timeout", 32'(wait_cnt), 32'd300);
            wait_cnt = 0;
         end
         if (cyc < 1500) Out_ready = ($urandom_range(0, 3) == 0);
         else Out_ready = ($urandom_range(0, 3) != 0);
         prev_ack = Ack_out;
         prev_valid = Out_valid;
         prev_ready = Out_ready;
         prev_data = Out_data;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
